// File: rtl/sobel_window.sv
// sobel_window: 3x3 pixel window generator for a raster video stream.
// Two line buffers hold rows r-1 and r-2; a column history feeds the window.
//
// Parameters:
//   LINE_W     pixels per line (3..2048)
//   COL_W      column counter width, at least ceil(log2(LINE_W))
// Ports:
//   clock      system clock, rising edge
//   reset      asynchronous active-high reset
//   pix_in     8-bit greyscale pixel
//   pix_valid  qualifies pix_in, sol and sof
//   sol        start of line (pixel is column 0)
//   sof        start of frame (row 0, column 0; implies sol)
//   z0..z8     window taps, z0-z2 top row, z6-z8 current row,
//              z0/z3/z6 oldest column, z2/z5/z8 newest
//   win_valid  one-cycle strobe qualifying z0..z8
// Build option:
//   SOBEL_WINDOW_ZERO_BORDER_EN  emit a window for every in-range pixel of
//   the frame, with taps outside the frame or line forced to 0.

module sobel_window #(
    parameter int LINE_W = 640,
    parameter int COL_W  = 11
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] pix_in,
    input  logic       pix_valid,
    input  logic       sol,
    input  logic       sof,
    output logic [7:0] z0,
    output logic [7:0] z1,
    output logic [7:0] z2,
    output logic [7:0] z3,
    output logic [7:0] z4,
    output logic [7:0] z5,
    output logic [7:0] z6,
    output logic [7:0] z7,
    output logic [7:0] z8,
    output logic       win_valid
);

    // One extra bit so the counter can park at LINE_W itself.
    localparam int CW = COL_W + 1;
    localparam int AW = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam logic [CW-1:0] COL_END = CW'(LINE_W);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0] col_q, col_d, col_eff;
    logic [1:0]    row_q, row_d, row_eff;
    logic          take, in_range, shift, wv_d;
    logic [AW-1:0] idx;

    logic [7:0] lb1 [LINE_W];
    logic [7:0] lb2 [LINE_W];
    logic [7:0] rd1, rd2;

    logic [7:0] top1, top2, mid1, mid2, bot1, bot2;
    logic [7:0] tap [9];

    // Position of the pixel presented this cycle.
    always_comb begin
        col_eff = (sof | sol) ? '0 : col_q;
        if (sof) begin
            row_eff = 2'd0;
        end else if (sol && row_q != 2'd2) begin
            row_eff = row_q + 2'd1;
        end else begin
            row_eff = row_q;
        end
        take     = pix_valid & (sof | (state_q != IDLE));
        in_range = col_eff < COL_END;
        shift    = take & in_range;
        idx      = col_eff[AW-1:0];
    end

    // Pre-write line buffer contents for this column.
    assign rd1 = lb1[idx];
    assign rd2 = lb2[idx];

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        if (take) begin
            col_d = in_range ? col_eff + CW'(1) : col_eff;
            row_d = row_eff;
            if (sof) begin
                state_d = FILL;
            end else if (state_q == FILL && row_eff == 2'd2) begin
                state_d = RUN;
            end
        end
    end

    always_comb begin
        tap[0] = top2;
        tap[1] = top1;
        tap[2] = rd2;
        tap[3] = mid2;
        tap[4] = mid1;
        tap[5] = rd1;
        tap[6] = bot2;
        tap[7] = bot1;
        tap[8] = pix_in;
`ifdef SOBEL_WINDOW_ZERO_BORDER_EN
        wv_d = shift;
        if (row_eff < 2'd2) begin
            tap[0] = 8'd0;
            tap[1] = 8'd0;
            tap[2] = 8'd0;
        end
        if (row_eff == 2'd0) begin
            tap[3] = 8'd0;
            tap[4] = 8'd0;
            tap[5] = 8'd0;
        end
        // History columns may hold the tail of the previous line.
        if (col_eff < CW'(2)) begin
            tap[0] = 8'd0;
            tap[3] = 8'd0;
            tap[6] = 8'd0;
        end
        if (col_eff == '0) begin
            tap[1] = 8'd0;
            tap[4] = 8'd0;
            tap[7] = 8'd0;
        end
`else
        wv_d = shift & (state_d == RUN) & (col_eff >= CW'(2));
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            col_q     <= '0;
            row_q     <= 2'd0;
            top1      <= 8'd0;
            top2      <= 8'd0;
            mid1      <= 8'd0;
            mid2      <= 8'd0;
            bot1      <= 8'd0;
            bot2      <= 8'd0;
            z0        <= 8'd0;
            z1        <= 8'd0;
            z2        <= 8'd0;
            z3        <= 8'd0;
            z4        <= 8'd0;
            z5        <= 8'd0;
            z6        <= 8'd0;
            z7        <= 8'd0;
            z8        <= 8'd0;
            win_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            win_valid <= wv_d;
            if (shift) begin
                top2 <= top1;
                top1 <= rd2;
                mid2 <= mid1;
                mid1 <= rd1;
                bot2 <= bot1;
                bot1 <= pix_in;
            end
            if (wv_d) begin
                z0 <= tap[0];
                z1 <= tap[1];
                z2 <= tap[2];
                z3 <= tap[3];
                z4 <= tap[4];
                z5 <= tap[5];
                z6 <= tap[6];
                z7 <= tap[7];
                z8 <= tap[8];
            end
        end
    end

    // Line buffers are never reset; window gating hides stale data.
    always_ff @(posedge clock) begin
        if (shift) begin
            lb2[idx] <= rd1;
            lb1[idx] <= pix_in;
        end
    end

endmodule

// File: tb/tb_sobel_window.sv
// tb_sobel_window: scoreboard bench for sobel_window with LINE_W = 8.
// Expected windows come from a frame image model kept by the bench.

module tb_sobel_window;

    localparam int LW = 8;

`ifdef SOBEL_WINDOW_ZERO_BORDER_EN
    localparam int            EXP_N     = 32;
    localparam logic [71:0]   EXP_FIRST = 72'h0;
`else
    localparam int            EXP_N     = 12;
    localparam logic [71:0]   EXP_FIRST = {8'h00, 8'h01, 8'h02, 8'h0A, 8'h0B,
                                           8'h0C, 8'h14, 8'h15, 8'h16};
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] pix_in = 8'd0;
    logic       pix_valid = 1'b0;
    logic       sol = 1'b0;
    logic       sof = 1'b0;
    logic [7:0] z0, z1, z2, z3, z4, z5, z6, z7, z8;
    logic       win_valid;

    always #5 clock = ~clock;

    sobel_window #(
        .LINE_W(LW),
        .COL_W (4)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .pix_in   (pix_in),
        .pix_valid(pix_valid),
        .sol      (sol),
        .sof      (sof),
        .z0       (z0),
        .z1       (z1),
        .z2       (z2),
        .z3       (z3),
        .z4       (z4),
        .z5       (z5),
        .z6       (z6),
        .z7       (z7),
        .z8       (z8),
        .win_valid(win_valid)
    );

    typedef struct {
        int          due;
        logic [71:0] win;
    } exp_t;

    exp_t        sbq[$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    int          n_wv = 0;
    bit          mon_en = 1'b0;
    bit          seen = 1'b0;
    logic [71:0] first_win = '0;
    logic [71:0] last_win = '0;
    logic [7:0]  img [0:15][0:LW-1];
    bit          m_act = 1'b0;
    int          m_row = 0;
    int          m_col = 0;

    wire [71:0] zvec = {z0, z1, z2, z3, z4, z5, z6, z7, z8};

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [71:0] got,
                         input logic [71:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (mon_en) begin
            if (win_valid === 1'b1) begin
                n_wv++;
                last_win = zvec;
                if (!seen) begin
                    first_win = zvec;
                    seen = 1'b1;
                end
            end
            if (sbq.size() > 0 && sbq[0].due <= cyc) begin
                e = sbq.pop_front();
                check("strobe", 72'(win_valid), 72'd1);
                check("window", zvec, e.win);
            end else begin
                check("quiet", 72'(win_valid), 72'd0);
            end
        end
    end

    task automatic model(input logic [7:0] p, input bit l, input bit f);
        logic [71:0] w;
        int          rr, cc;
        bit          ok;
        if (f) begin
            m_act = 1'b1;
            m_row = 0;
            m_col = 0;
        end else if (!m_act) begin
            return;
        end else if (l) begin
            m_row++;
            m_col = 0;
        end
        if (m_col < LW) begin
            img[m_row][m_col] = p;
`ifdef SOBEL_WINDOW_ZERO_BORDER_EN
            ok = 1'b1;
`else
            ok = (m_row >= 2) && (m_col >= 2);
`endif
            if (ok) begin
                w = '0;
                for (int dr = 0; dr < 3; dr++) begin
                    for (int dc = 0; dc < 3; dc++) begin
                        rr = m_row - 2 + dr;
                        cc = m_col - 2 + dc;
                        w = {w[63:0], (rr < 0 || cc < 0) ? 8'h00 : img[rr][cc]};
                    end
                end
                sbq.push_back('{cyc + 1, w});
            end
        end
        m_col++;
    endtask

    task automatic drive(input logic [7:0] p, input bit v, input bit l,
                         input bit f);
        @(posedge clock);
        #1;
        pix_in    = p;
        pix_valid = v;
        sol       = l;
        sof       = f;
        if (v) model(p, l, f);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic frame(input int rows, input int row0_len, input bit gaps,
                         input bit rnd, input bit both);
        int         len;
        logic [7:0] p;
        for (int r = 0; r < rows; r++) begin
            len = (r == 0) ? row0_len : LW;
            for (int c = 0; c < len; c++) begin
                p = rnd ? 8'($urandom_range(0, 255)) : 8'(10 * r + c);
                drive(p, 1'b1, (c == 0) && (r > 0 || both), (r == 0) && (c == 0));
                // Garbage on an unqualified cycle must be ignored.
                if (gaps) drive(8'hFF, 1'b0, 1'b1, 1'b1);
            end
        end
    endtask

    task automatic run_frame(input string tag, input int row0_len,
                             input bit gaps, input bit rnd, input bit both);
        n_wv = 0;
        seen = 1'b0;
        frame(4, row0_len, gaps, rnd, both);
        idle(4);
        check({tag, "_count"}, 72'(n_wv), 72'(EXP_N));
        check({tag, "_drain"}, 72'(sbq.size()), 72'd0);
        if (!rnd) begin
            check({tag, "_first"}, first_win, EXP_FIRST);
            check({tag, "_last_z8"}, 72'(last_win[7:0]), 72'd37);
            check({tag, "_last_z0"}, 72'(last_win[71:64]), 72'd15);
        end
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check("rst_z", zvec, 72'd0);
        check("rst_wv", 72'(win_valid), 72'd0);
        reset  = 1'b0;
        mon_en = 1'b1;
        idle(2);

        run_frame("basic", LW, 1'b0, 1'b0, 1'b0);
        run_frame("gaps", LW, 1'b1, 1'b0, 1'b0);
        run_frame("long", LW + 2, 1'b0, 1'b0, 1'b0);
        run_frame("rand", LW, 1'b0, 1'b1, 1'b1);
        run_frame("sofsol", LW, 1'b0, 1'b0, 1'b1);

        // Break a frame in row 3 with a reset, then send lines without sof.
        frame(3, LW, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) drive(8'(30 + c), 1'b1, c == 0, 1'b0);
        idle(2);
        @(posedge clock);
        #1;
        reset = 1'b1;
        m_act = 1'b0;
        #1;
        check("rst_async_z", zvec, 72'd0);
        check("rst_async_wv", 72'(win_valid), 72'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        n_wv = 0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < LW; c++) drive(8'(c + 100), 1'b1, c == 0, 1'b0);
        end
        idle(3);
        check("nosof_count", 72'(n_wv), 72'd0);
        check("nosof_drain", 72'(sbq.size()), 72'd0);

        run_frame("restart", LW, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sobel_window.md
SOBEL_WINDOW -- requirements
Module: sobel_window

Interface
REQ-001 SHALL have parameter LINE_W, default 640, meaning pixels per video line; legal range 3..2048.
REQ-002 SHALL have parameter COL_W, default 11, meaning column-counter width; ceil(log2(LINE_W)) <= COL_W.
REQ-003 SHALL have port clock, input, 1, the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port pix_in, input, 8, unsigned greyscale pixel.
REQ-006 SHALL have port pix_valid, input, 1, qualifies pix_in, sol and sof for one cycle.
REQ-007 SHALL have port sol, input, 1, start of line; the pixel with sol is column 0.
REQ-008 SHALL have port sof, input, 1, start of frame; implies sol; the pixel with sof is row 0, column 0.
REQ-009 SHALL have ports z0..z8, output, 8 each, 3x3 window: z0-z2 top row (two lines back), z3-z5 middle, z6-z8 bottom (current line); z0/z3/z6 oldest column, z2/z5/z8 newest.
REQ-010 SHALL have port win_valid, output, 1, one-cycle strobe qualifying z0..z8.

Function
REQ-011 SHALL store two previous lines in line buffers lb1 (row r-1) and lb2 (row r-2), LINE_W x 8 each.
REQ-012 On an accepted pixel at column c: SHALL write lb2[c] <= lb1[c] and lb1[c] <= pix_in, using the pre-write values for the window.
REQ-013 SHALL shift three 3-entry column registers per accepted pixel: bottom <= pix_in, middle <= lb1[c], top <= lb2[c].
REQ-014 SHALL register z0..z8 and win_valid with latency exactly 1 clock after the accepting edge; win_valid is low on cycles with no accepted pixel.
REQ-015 SHALL implement an FSM: IDLE (discard pixels until sof), FILL (rows 0-1), RUN (row >= 2).
REQ-016 Transitions SHALL be: IDLE->FILL on accepted sof; FILL->RUN on accepted sol starting row 2; any state->FILL on accepted sof.
REQ-017 The column counter SHALL reset to 0 on sol/sof and increment per accepted pixel; the row counter SHALL increment on sol and saturate at 2.
REQ-018 Pixels accepted at column >= LINE_W SHALL be dropped: no buffer write, no shift, win_valid low; the counter holds at LINE_W.
REQ-019 Without the macro in REQ-025, win_valid SHALL assert only in RUN with the accepted pixel's column >= 2; the window is then centred on (row-1, col-1).
REQ-020 A sol arriving mid-line (short line) SHALL start a new line normally; unwritten buffer entries retain their old contents.
REQ-021 Simultaneous sof and sol SHALL be treated as sof.

Reset
REQ-022 While reset is high, z0..z8 SHALL be 0, win_valid 0, counters 0 and the FSM IDLE, regardless of clock.
REQ-023 Line-buffer contents SHALL NOT be reset; stale data SHALL be unobservable through win_valid.
REQ-024 Reset deasserted mid-frame SHALL discard input until the next sof.

Configuration
REQ-025 Macro SOBEL_WINDOW_ZERO_BORDER_EN: when defined, win_valid SHALL assert for every in-range accepted pixel in FILL or RUN. Taps referencing rows before row 0 of the current frame SHALL read 0. Taps referencing columns before column 0 of the current line SHALL read 0.
REQ-026 When SOBEL_WINDOW_ZERO_BORDER_EN is undefined, REQ-019 gating SHALL apply and no zero-masking logic SHALL be built.

Verification
REQ-027 LINE_W=8; frame pix = 10*row+col, 4 rows -> first win_valid 1 clock after row 2 col 2; z0..z8 = 0,1,2,10,11,12,20,21,22.
REQ-028 Same frame -> exactly 12 win_valid strobes (rows 2-3 x cols 2-7); last window z8=37, z0=15.
REQ-029 pix_valid toggling 1-0-1 every cycle -> identical window values to REQ-027; win_valid low on idle cycles.
REQ-030 10 pixels on one line with LINE_W=8 -> pixels 8-9 dropped; next line's buffer column 0 holds pixel 0.
REQ-031 reset pulsed mid-row 3, then pixels without sof -> win_valid stays 0; next sof restarts and REQ-027 reproduces.
REQ-032 SOBEL_WINDOW_ZERO_BORDER_EN defined, REQ-027 frame -> first strobe at row 0 col 0 with z8=0 (pixel 0) and all other taps 0; row 1 col 1 -> z4=0, z5=1, z7=10, z8=11, others 0; 32 strobes total.
